vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have port vga_clk, input, 1 bit: pixel clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port pix_en, input, 1 bit: pixel-advance enable; the counters step only on cycles where it is high.
REQ-004 SHALL have port DrawX, output, 10 bits: current horizontal position, 0..799.
REQ-005 SHALL have port DrawY, output, 10 bits: current vertical position, 0..524.
REQ-006 SHALL have port hs, output, 1 bit: horizontal sync, active-low.
REQ-007 SHALL have port vs, output, 1 bit: vertical sync, active-low.
REQ-008 SHALL have port blank, output, 1 bit: display-enable; high means the pixel is visible and may be driven.
REQ-009 SHALL have port frame_start, output, 1 bit: one-cycle pulse marking entry to position (0,0).
REQ-010 SHALL have port frame_count, output, 8 bits: count of completed frames.

Function
REQ-011 SHALL use these horizontal timings, in pixels: visible 640, front porch 16, sync 96, back porch 48, total 800.
REQ-012 SHALL use these vertical timings, in lines: visible 480, front porch 10, sync 2, back porch 33, total 525.
REQ-013 SHALL, when pix_en=1, increment DrawX; at DrawX=799 it SHALL set DrawX to 0 and increment DrawY.
REQ-014 SHALL, when pix_en=1 at (799,524), set DrawX=0 and DrawY=0 (frame wrap).
REQ-015 SHALL, when pix_en=0, hold every output except frame_start, which is 0 on that cycle.
REQ-016 SHALL register all outputs and keep them coherent: in any cycle, hs, vs and blank correspond to the DrawX/DrawY values presented in that same cycle (next-state decode, zero skew).
REQ-017 SHALL drive hs=0 exactly for DrawX 656..751, and 1 otherwise.
REQ-018 SHALL drive vs=0 exactly for DrawY 490..491, and 1 otherwise.
REQ-019 SHALL drive blank=1 exactly when DrawX<640 and DrawY<480.
REQ-020 SHALL raise frame_start for exactly one cycle, on the cycle DrawX/DrawY become (0,0) through a frame wrap.
REQ-021 SHALL not raise frame_start on reset release.
REQ-022 SHALL never let either counter exceed its terminal value; an out-of-range value (e.g. from an SEU) SHALL wrap to 0 on the next pix_en.
REQ-023 SHALL run free; there is no back-pressure path, and downstream sprite/ROM readers sample on the following clock edge.

Reset
REQ-024 SHALL, while reset=1, immediately force DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, frame_count=0, independent of vga_clk.
REQ-025 SHALL, after a reset applied mid-frame, restart at (0,0); the first advance after release SHALL go to (1,0).
REQ-026 SHALL give reset priority over pix_en.

Configuration
REQ-027 SHALL recognise the macro VGA_FRAME_COUNT_EN.
REQ-028 SHALL, with VGA_FRAME_COUNT_EN defined, increment frame_count modulo 256 on each frame_start pulse (255 -> 0).
REQ-029 SHALL, without VGA_FRAME_COUNT_EN, keep the frame_count port present, tie it to 0, and include no counter logic.
REQ-030 SHALL leave all other behaviour unchanged by the macro.

Verification
REQ-031 SHALL cover reset asserted mid-line at (300,200) -> outputs immediately (0,0), hs=1, vs=1, blank=1, frame_count=0.
REQ-032 SHALL cover pix_en=1 for 800 cycles from reset -> DrawX=0, DrawY=1; hs=0 on exactly 96 of those cycles (x 656..751); blank=0 first at x=640.
REQ-033 SHALL cover running to line 490 -> vs=0 for lines 490 and 491 (1600 cycles), then vs=1 at (0,492).
REQ-034 SHALL cover 420000 advances from reset -> back at (0,0), one frame_start pulse; frame_count=1 with the macro, 0 without it.
REQ-035 SHALL cover pix_en toggling 1,0,1,0 starting at (799,524) -> wrap on the first pix_en=1, frame_start high one cycle only, outputs held at (0,0) while pix_en=0, (1,0) after the next pix_en=1.
REQ-036 SHALL cover 256 full frames with the macro -> frame_count returns to 0, frame_start pulsed 256 times.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 640x480@60 VGA raster timing generator.
// Counters advance on pix_en; hs/vs/blank are decoded from the next counter
// state and registered together with DrawX/DrawY, so all outputs line up
// in the same cycle. Timing parameters default to the standard 800x525 raster.
// Optional feature: define VGA_FRAME_COUNT_EN to enable the 8-bit frame counter;
// without it frame_count is tied to zero.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    // Terminal counts and decode boundaries (sync window end is exclusive)
    localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);

    logic [9:0] r_draw_x;
    logic [9:0] r_draw_y;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_frame_start;

    logic       w_x_last;
    logic       w_y_last;
    logic       w_frame_wrap;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_hs_next;
    logic       w_vs_next;
    logic       w_blank_next;

    // Next-position logic; ">=" lets a corrupted out-of-range count recover to 0
    always_comb begin
        w_x_last     = (r_draw_x >= H_LAST);
        w_y_last     = (r_draw_y >= V_LAST);
        w_frame_wrap = w_x_last && w_y_last;
        w_x_next     = w_x_last ? 10'd0 : r_draw_x + 10'd1;
        if (w_x_last) begin
            w_y_next = w_y_last ? 10'd0 : r_draw_y + 10'd1;
        end else if (r_draw_y > V_LAST) begin
            w_y_next = 10'd0;
        end else begin
            w_y_next = r_draw_y;
        end
    end

    // Decode sync/blank from the next position so they register alongside it
    always_comb begin
        w_hs_next    = !((w_x_next >= H_SYNC_START) && (w_x_next < H_SYNC_END));
        w_vs_next    = !((w_y_next >= V_SYNC_START) && (w_y_next < V_SYNC_END));
        w_blank_next = (w_x_next < H_VIS_END) && (w_y_next < V_VIS_END);
    end

    // Raster state: reset wins, otherwise step only when pix_en is high
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_draw_x      <= 10'd0;
            r_draw_y      <= 10'd0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_draw_x      <= w_x_next;
            r_draw_y      <= w_y_next;
            r_hs          <= w_hs_next;
            r_vs          <= w_vs_next;
            r_blank       <= w_blank_next;
            r_frame_start <= w_frame_wrap;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    // Frame counter steps on the same edge that raises frame_start; wraps mod 256
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= 8'd0;
        end else if (pix_en && w_frame_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 8'd0;
`endif

    assign DrawX       = r_draw_x;
    assign DrawY       = r_draw_y;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;

endmodule
